// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-client round-robin arbiter with a bounded grant tenure.
// The pointer holds the last grantee, so that client has the lowest priority at the
// next arbitration. Every release passes through IDLE, which gives one dead cycle
// between tenures.
module rr_arbiter4 #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout,
   output logic [1:0] ptr
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

   state_e           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       gnt_id_q, gnt_id_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [1:0]       ptr_q, ptr_d;

   logic             found;
   logic [1:0]       winner;
   logic [1:0]       idx;

   // Circular search for the first requester, starting just after the pointer.
   always_comb begin
      found  = 1'b0;
      winner = 2'd0;
      idx    = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // Next-state logic: arbitrate in IDLE, release on req drop or hold limit in GRANT.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      hold_cnt_d  = hold_cnt_q;
      ptr_d       = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d     = StGrant;
               gnt_d       = 4'b0001 << winner;
               gnt_id_d    = winner;
               gnt_valid_d = 1'b1;
               hold_cnt_d  = '0;
            end
         end
         StGrant: begin
            if (!req[gnt_id_q] || (hold_cnt_q == HoldLast)) begin
               state_d     = StIdle;
               gnt_d       = 4'b0000;
               gnt_valid_d = 1'b0;
               hold_cnt_d  = '0;
               ptr_d       = gnt_id_q;
               // Only a forced release (client still requesting) flags a timeout.
               timeout_d   = req[gnt_id_q];
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers; reset wins immediately, without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         gnt_q       <= 4'b0000;
         gnt_id_q    <= 2'b00;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         hold_cnt_q  <= '0;
         ptr_q       <= 2'b11;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         hold_cnt_q  <= hold_cnt_d;
         ptr_q       <= ptr_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;
   assign ptr       = ptr_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Testbench for rr_arbiter4: directed table, hand-written corner sequences and
// randomized traffic compared against a behavioural model.
module tb_rr_arbiter4;

   localparam int MH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;
   logic [1:0] ptr;

   logic [3:0] req1 = 4'b0000;
   logic [3:0] gnt1;
   logic [1:0] gnt_id1;
   logic       gnt_valid1;
   logic       timeout1;
   logic [1:0] ptr1;

   int total  = 0;
   int passed = 0;

   // Model state: current owner (-1 = none), cycles granted so far, last grantee.
   int m_owner;
   int m_ten;
   int m_last;
   bit m_to;

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic       to;
      logic [1:0] ptr;
   } vec_t;

   vec_t tbl[11];

   rr_arbiter4 #(.MAX_HOLD(MH), .CNT_W(4)) dut8 (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_id(gnt_id),
      .gnt_valid(gnt_valid), .timeout(timeout), .ptr(ptr)
   );

   rr_arbiter4 #(.MAX_HOLD(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .req(req1), .gnt(gnt1), .gnt_id(gnt_id1),
      .gnt_valid(gnt_valid1), .timeout(timeout1), .ptr(ptr1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ten   = 0;
      m_last  = 3;
      m_to    = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] r);
      m_to = 1'b0;
      if (m_owner < 0) begin
         for (int k = 1; k <= 4; k++) begin
            if (m_owner < 0 && r[(m_last + k) % 4]) begin
               m_owner = (m_last + k) % 4;
               m_ten   = 1;
            end
         end
      end else if (!r[m_owner] || m_ten == MH) begin
         m_to    = r[m_owner];
         m_last  = m_owner;
         m_owner = -1;
      end else begin
         m_ten++;
      end
   endtask

   task automatic invariants(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic v, input logic to);
      chk({tag, "_onehot0"}, 32'($countones(g) <= 1), 32'd1);
      chk({tag, "_valid_or"}, 32'(v), 32'(|g));
      if (v) chk({tag, "_id_match"}, 32'(g), 32'(4'b0001 << id));
      chk({tag, "_to_vs_valid"}, 32'(to && v), 32'd0);
   endtask

   task automatic compare_model();
      logic [3:0] eg;
      eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      chk("model_gnt", 32'(gnt), 32'(eg));
      chk("model_timeout", 32'(timeout), 32'(m_to));
      chk("model_ptr", 32'(ptr), 32'(m_last));
      if (m_owner >= 0) chk("model_gnt_id", 32'(gnt_id), 32'(m_owner));
   endtask

   // One clock: model consumes the req the DUT samples, outputs checked 1 unit later.
   task automatic step();
      @(posedge clk);
      model_step(req);
      #1;
      compare_model();
      invariants("d8", gnt, gnt_id, gnt_valid, timeout);
      invariants("d1", gnt1, gnt_id1, gnt_valid1, timeout1);
   endtask

   task automatic do_reset();
      req  = 4'b0000;
      req1 = 4'b0000;
      rst  = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_gnt_valid", 32'(gnt_valid), 32'h0);
      chk("rst_gnt_id", 32'(gnt_id), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
      chk("rst_ptr", 32'(ptr), 32'h3);
      chk("rst_ptr1", 32'(ptr1), 32'h3);
      rst = 1'b0;
   endtask

   initial begin
      // Table: req applied before the edge, expected outputs after it.
      tbl[0]  = '{4'b0001, 4'b0001, 1'b0, 2'd3};
      tbl[1]  = '{4'b0001, 4'b0001, 1'b0, 2'd3};
      tbl[2]  = '{4'b0001, 4'b0001, 1'b0, 2'd3};
      tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
      tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
      tbl[5]  = '{4'b0010, 4'b0010, 1'b0, 2'd0};
      tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 2'd1};
      tbl[7]  = '{4'b0101, 4'b0100, 1'b0, 2'd1};
      tbl[8]  = '{4'b0001, 4'b0000, 1'b0, 2'd2};
      tbl[9]  = '{4'b0001, 4'b0001, 1'b0, 2'd2};
      tbl[10] = '{4'b0000, 4'b0000, 1'b0, 2'd0};

      do_reset();
      for (int i = 0; i < 11; i++) begin
         req = tbl[i].req;
         step();
         chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
         chk($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'(tbl[i].to));
         chk($sformatf("tbl%0d_ptr", i), 32'(ptr), 32'(tbl[i].ptr));
      end

      // All four requesting: order 0,1,2,3,0, each forced out after MH cycles.
      do_reset();
      req = 4'b1111;
      for (int t = 0; t < 4; t++) begin
         for (int c = 0; c < MH; c++) begin
            step();
            chk($sformatf("rr_t%0d_c%0d_gnt", t, c), 32'(gnt), 32'(1 << t));
         end
         step();
         chk($sformatf("rr_t%0d_dead_gnt", t), 32'(gnt), 32'h0);
         chk($sformatf("rr_t%0d_timeout", t), 32'(timeout), 32'h1);
         chk($sformatf("rr_t%0d_ptr", t), 32'(ptr), 32'(t));
      end
      step();
      chk("rr_wrap_gnt", 32'(gnt), 32'h1);

      // Client 3 held past the limit with client 0 waiting: wrap 3 -> 0.
      do_reset();
      req = 4'b0100;
      step();
      req = 4'b0000;
      step();
      chk("c3_setup_ptr", 32'(ptr), 32'h2);
      req = 4'b1001;
      for (int c = 0; c < MH; c++) begin
         step();
         chk($sformatf("c3_hold%0d", c), 32'(gnt), 32'h8);
         chk($sformatf("c3_to%0d", c), 32'(timeout), 32'h0);
      end
      step();
      chk("c3_dead_gnt", 32'(gnt), 32'h0);
      chk("c3_timeout", 32'(timeout), 32'h1);
      chk("c3_ptr", 32'(ptr), 32'h3);
      step();
      chk("c3_next_gnt", 32'(gnt), 32'h1);
      chk("c3_next_timeout", 32'(timeout), 32'h0);

      // Asynchronous reset mid-grant, then a fresh full budget.
      do_reset();
      req = 4'b0100;
      repeat (5) step();
      chk("mid_pre_gnt", 32'(gnt), 32'h4);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("mid_rst_gnt", 32'(gnt), 32'h0);
      chk("mid_rst_valid", 32'(gnt_valid), 32'h0);
      chk("mid_rst_ptr", 32'(ptr), 32'h3);
      chk("mid_rst_timeout", 32'(timeout), 32'h0);
      #1;
      rst = 1'b0;
      for (int c = 0; c < MH; c++) begin
         step();
         chk($sformatf("mid_fresh%0d", c), 32'(gnt), 32'h4);
      end
      step();
      chk("mid_dead_gnt", 32'(gnt), 32'h0);
      chk("mid_timeout", 32'(timeout), 32'h1);

      // MAX_HOLD=1: grant alternates with a timeout cycle.
      do_reset();
      req1 = 4'b0010;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("mh1_gnt%0d", i), 32'(gnt1), (i % 2 == 0) ? 32'h2 : 32'h0);
         chk($sformatf("mh1_to%0d", i), 32'(timeout1), (i % 2 == 1) ? 32'h1 : 32'h0);
      end
      chk("mh1_ptr", 32'(ptr1), 32'h1);

      // Randomized traffic against the model; bits flip with 1/8 probability per cycle.
      do_reset();
      for (int i = 0; i < 500; i++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
         req1 = 4'($urandom_range(0, 15));
         step();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one resource, e.g. a counter or datapath slot, among up to four clients.
- A 2-bit wrapping priority pointer rotates priority after every grant.
- A hold counter bounds each tenure so no requester can monopolise the resource.
- Sits between client request lines and the shared block's enable/select inputs.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles a grantee may hold the grant. Legal range 1..15.
- CNT_W, 4, hold-counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- req  input  4  level request per client; bit i = client i; held high while the client wants or uses the resource
- gnt  output 4  one-hot registered grant; all-zero when idle
- gnt_id  output 2  index of the current grantee; valid only when gnt_valid=1
- gnt_valid  output 1  high when any grant is active; equals OR of gnt
- timeout  output 1  one-cycle pulse when a grant is force-released by MAX_HOLD
- ptr  output 2  current priority pointer, exported for debug

Behaviour:
- Clocking and reset:
  - Single clock domain. All outputs are registered.
  - rst asserted at any time, including mid-grant, immediately forces: state=IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, timeout=0, hold_cnt=0, ptr=2'b11.
  - ptr=2'b11 after reset makes the first search order 0,1,2,3.
- States:
  - IDLE: no grant.
  - GRANT: exactly one gnt bit high.
- IDLE:
  - If req!=0 at a rising edge, enter GRANT at that edge.
  - Winner is the first set req bit searched circularly from (ptr+1) mod 4 upward, wrapping 3->0.
  - Load gnt=one-hot(winner), gnt_id=winner, hold_cnt=0.
  - If req==0, remain in IDLE.
  - Latency: a request is visible on gnt one edge after it is sampled.
- GRANT, evaluated each rising edge with id=gnt_id:
  - Normal release, req[id]==0: gnt<=0, go to IDLE, ptr<=id, timeout stays 0.
  - Forced release, req[id]==1 and hold_cnt==MAX_HOLD-1: gnt<=0, go to IDLE, ptr<=id, timeout<=1 for exactly one cycle.
  - Otherwise: hold_cnt<=hold_cnt+1, grant unchanged.
  - Changes on other req bits are ignored while granted; there is no preemption.
- Every release passes through IDLE, so each handover has exactly one dead cycle with gnt=0 between tenures.
- Because ptr=last grantee, that client has lowest priority at the next arbitration.
  - A lone requester is re-granted after the dead cycle.
  - A forced-out client that keeps req high is served again only after the other pending clients.
- Grant length:
  - Normal release: gnt is high for exactly the number of edges req[id] stayed high after the grant, i.e. gnt drops one edge after req drops.
  - Forced release: gnt is high for exactly MAX_HOLD cycles.
- ptr arithmetic is 2-bit modulo; 3+1 wraps to 0. ptr changes only on release.
- hold_cnt is CNT_W bits and never exceeds MAX_HOLD-1. It is reset to 0 on each new grant.
- MAX_HOLD=1: every grant lasts one cycle, and timeout pulses whenever req is still high at the release edge.
- timeout is never asserted in the same cycle as gnt_valid.
- Invariants, checked by the bench:
  - gnt is always one-hot or zero.
  - gnt_valid==|gnt.
  - gnt_id matches the set gnt bit whenever gnt_valid=1.

Test Plan:
- Reset then req=4'b0001 held 3 cycles, then dropped -> gnt=0001 for 3 cycles starting one edge after req; ptr=0; timeout never asserted.
- After reset, req=4'b1111 held constant, MAX_HOLD=8 -> grant order 0,1,2,3,0; each tenure 8 cycles with timeout pulse; one idle cycle between tenures; ptr sequence 0,1,2,3.
- ptr=1 and req=4'b0101 asserted simultaneously from IDLE -> client 2 granted first (search 2,3,0,1); after its release, client 0 granted.
- Client 3 granted, req[3] held past MAX_HOLD with req[0] high -> gnt=1000 for exactly 8 cycles; timeout=1 for one cycle; one dead cycle; then gnt=0001 (wrap 3->0).
- rst pulsed mid-grant on client 2 (hold_cnt=4) -> gnt=0, ptr=3, timeout=0 immediately, without waiting for a clock; after rst drops with req=4'b0100, client 2 is granted with a fresh 8-cycle budget.
- MAX_HOLD=1, req=4'b0010 held -> gnt pattern high, low, high, low; timeout pulses on every low cycle.
